// File: rtl/seq_det_pkg.sv
// Shared encodings and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic found    = 1'b1;
  localparam logic notfound = 1'b0;

  // Ceiling log2 for elaboration-time widths; valid for 1 <= value <= 2**30.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_hist_shift.sv
// History shift register of the last PAT_W-1 accepted bits plus a saturating fill count.
module seq_hist_shift
  import seq_det_pkg::*;
#(
  parameter int PAT_W  = 4,
  parameter int FILL_W = clog2(PAT_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift,
  input  logic              flush,
  input  logic              din,
  output logic [PAT_W-2:0]  hist,
  output logic [FILL_W-1:0] fill
);

  localparam int HW = PAT_W - 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(HW);

  logic [HW-1:0] hist_next;

  // A 1-bit history cannot be sliced below its MSB, so it just takes the new bit.
  generate
    if (HW == 1) begin : g_one
      assign hist_next = din;
    end else begin : g_many
      assign hist_next = {hist[HW-2:0], din};
    end
  endgenerate

  // flush wins over shift: clear and non-overlapping matches both restart history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (flush) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_next;
      if (fill != FILL_FULL) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised MSB-first serial pattern detector with overlap/halt modes and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
  parameter int             CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    x,
  input  logic                    overlap,
  input  logic                    halt_on_match,
  input  logic                    clear,
  output logic                    y,
  output logic                    y_q,
  output logic [CNT_W-1:0]        match_count,
  output logic                    halted,
  output logic [clog2(PAT_W):0]   fill
);

  localparam int FILL_W = clog2(PAT_W) + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  // en is a plain sample strobe, not a handshake: x is consumed on every cycle
  // with en=1 while running and not clearing; there is no back-pressure.
  state_t            state, state_next;
  logic [PAT_W-2:0]  hist;
  logic              m;
  logic              shift;
  logic              flush;

  seq_hist_shift #(
    .PAT_W  (PAT_W),
    .FILL_W (FILL_W)
  ) u_hist (
    .clk   (clk),
    .reset (reset),
    .shift (shift),
    .flush (flush),
    .din   (x),
    .hist  (hist),
    .fill  (fill)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear)                    state_next = ST_RUN;
    else if (m && halt_on_match)  state_next = ST_HALTED;
  end

  always_comb begin
    m = notfound;
    if (en && (state == ST_RUN) && !clear && (fill == FILL_FULL) && ({hist, x} == PATTERN))
      m = found;
    y      = m;
    halted = (state == ST_HALTED);
  end

  // A non-overlapping match discards history instead of shifting the last bit in.
  assign flush = clear | (m & ~overlap);
  assign shift = en & (state == ST_RUN) & ~clear & ~(m & ~overlap);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
      y_q         <= 1'b0;
    end else begin
      y_q <= m;
      if (clear)                        match_count <= '0;
      else if (m && (match_count != '1)) match_count <= match_count + 1'b1;
    end
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector; successor to the fixed 4-bit Mealy "1001" detector.
- Matches an arbitrary PAT_W-bit pattern on a 1-bit input stream, MSB first.
- Selectable overlapping/non-overlapping detection, optional halt-on-match, saturating match counter, Mealy and registered outputs.
- Sits in the lab/guide designs as the reusable detector feeding counters and display logic.

Parameters:
PAT_W, 4, pattern length in bits (2..16)
PATTERN, 4'b1001, target sequence; bit PAT_W-1 is received first
CNT_W, 8, width of match counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
en  input  1  sample enable; x is consumed only on cycles with en=1
x  input  1  serial data bit
overlap  input  1  1: overlapping matches allowed; 0: history discarded after each match
halt_on_match  input  1  1: stop detecting after first match until clear
clear  input  1  synchronous clear of history, fill, halt and counter
y  output  1  Mealy match flag (combinational, same cycle as last pattern bit)
y_q  output  1  y registered (one-cycle latency)
match_count  output  CNT_W  saturating count of matches
halted  output  1  high while in HALTED state
fill  output  clog2(PAT_W)+1  number of valid history bits (0..PAT_W-1)

Behaviour:
- Reset (reset=0, asynchronous): hist=0, fill=0, state=RUN, y_q=0, match_count=0, halted=0. y=0 while reset is low.
- State machine: two states.
  - RUN: detecting.
  - HALTED: entered on the clock edge of a match when halt_on_match=1; left only by clear or reset.
- History: hist holds the last PAT_W-1 accepted bits. On an edge with en=1 in RUN and no clear:
  - hist <= {hist[PAT_W-3:0], x}.
  - fill <= min(fill+1, PAT_W-1).
- Match condition (combinational):
  - m = en & (state==RUN) & ~clear & (fill==PAT_W-1) & ({hist, x}==PATTERN).
  - y = m.
- On an edge with m=1:
  - match_count increments, saturating at all-ones (no wrap).
  - If overlap=0: fill <= 0 (hist contents then irrelevant).
  - If overlap=1: normal shift/fill update.
  - If halt_on_match=1: state <= HALTED.
- y_q <= m on every edge (y_q is 0 the cycle after reset/clear).
- en=0: hist, fill, and state hold; y=0; y_q <= 0.
- HALTED: x ignored; hist, fill, and count frozen; y=0.
- clear=1 (synchronous, priority over en/match): hist=0, fill=0, count=0, state=RUN, y_q<=0; a match coincident with clear is not counted.
- Mode inputs are sampled every cycle; changing overlap mid-stream affects only subsequent matches.
- PAT_W=2 edge case: hist is a single bit; same rules apply.

Decomposition:
- Package seq_det_pkg:
  - state encodings ST_RUN=1'b0, ST_HALTED=1'b1.
  - `found`/`notfound` constants (1/0).
  - clog2 helper function for fill width.
- One sub-module: seq_hist_shift.
  - Contains the PAT_W-1 shift register and fill counter.
  - Inputs: shift, flush.
  - Outputs: hist, fill.
- The top level holds the FSM, compare, counter, and y_q.

Test Plan:
- Overlap mode: PATTERN=1001, overlap=1, en=1, x=1,0,0,1,0,0,1 -> y=1 on the 4th and 7th bits only, y_q one cycle later each time, match_count=2.
- Non-overlap mode: same stream with overlap=0 -> y=1 on the 4th bit only; fill returns to 0 after the match; match_count=1.
- Halt and clear: halt_on_match=1, x=1,0,0,1 then 0,0,1 -> halted=1 after the first match; second pattern ignored; count=1. Then clear=1 for one cycle, then x=1,0,0,1 -> halted=0 and count=1 after the new match.
- Counter saturation: CNT_W=2, overlap=1, stream 1001001001001001 (5 matches) -> match_count reaches 3 and stays 3.
- Enable gating: x=1,0 with en=1, then three cycles en=0 with x=1, then en=1 with x=0,1 -> exactly one match on the final bit; y=0 throughout the en=0 cycles.
- Mid-operation reset: x=1,0,0 then reset pulsed low mid-cycle, then x=1 -> outputs zero immediately on reset; no match since fill=1; count=0. Then 0,0,1 -> match.
